// File: rtl/regfile_hilo_pkg.sv
// Shared widths and write-back bus field offsets for the register file slice.
package regfile_hilo_pkg;

    localparam int unsigned WB_TO_RF_WD = 104;
    localparam int unsigned RegAddrBus  = 5;
    localparam int unsigned RegBus      = 32;

    localparam int unsigned RF_WDATA_LSB = 0;
    localparam int unsigned RF_WADDR_LSB = 32;
    localparam int unsigned RF_WE_BIT    = 37;
    localparam int unsigned HI_WE_BIT    = 38;
    localparam int unsigned HI_I_LSB     = 39;
    localparam int unsigned LO_WE_BIT    = 71;
    localparam int unsigned LO_I_LSB     = 72;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair, async active-low reset.
// Optional write-through when RF_BYPASS_EN is defined.
module hilo_reg
    import regfile_hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hi_we,
    input  logic [RegBus-1:0] hi_i,
    input  logic              lo_we,
    input  logic [RegBus-1:0] lo_i,
    output logic [RegBus-1:0] hi_rdata,
    output logic [RegBus-1:0] lo_rdata
);

    logic [RegBus-1:0] hi_q;
    logic [RegBus-1:0] lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_i;
            if (lo_we) lo_q <= lo_i;
        end
    end

    always_comb begin
        hi_rdata = hi_q;
        lo_rdata = lo_q;
`ifdef RF_BYPASS_EN
        // Bypass is gated by reset so outputs read zero while reset is held.
        if (rst && hi_we) hi_rdata = hi_i;
        if (rst && lo_we) lo_rdata = lo_i;
`endif
    end

endmodule

// File: rtl/regfile_hilo.sv
// Write-back register file: 31 GPRs ($0 hardwired to zero) plus HI/LO.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module regfile_hilo
    import regfile_hilo_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [RegAddrBus-1:0]  raddr1,
    output logic [RegBus-1:0]      rdata1,
    input  logic [RegAddrBus-1:0]  raddr2,
    output logic [RegBus-1:0]      rdata2,
    output logic [RegBus-1:0]      hi_rdata,
    output logic [RegBus-1:0]      lo_rdata
);

    logic [RegBus-1:0]     rf_wdata;
    logic [RegAddrBus-1:0] rf_waddr;
    logic                  rf_we;
    logic                  hi_we;
    logic [RegBus-1:0]     hi_i;
    logic                  lo_we;
    logic [RegBus-1:0]     lo_i;

    // Field order must track the write-back stage's packing.
    assign {lo_i, lo_we, hi_i, hi_we, rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;

    logic [RegBus-1:0] gpr [1:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (rf_we && rf_waddr != '0) begin
            gpr[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = gpr[raddr1];
`ifdef RF_BYPASS_EN
            if (rst && rf_we && rf_waddr == raddr1) rdata1 = rf_wdata;
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = gpr[raddr2];
`ifdef RF_BYPASS_EN
            if (rst && rf_we && rf_waddr == raddr2) rdata2 = rf_wdata;
`endif
        end
    end

    hilo_reg u_hilo_reg (
        .clk      (clk),
        .rst      (rst),
        .hi_we    (hi_we),
        .hi_i     (hi_i),
        .lo_we    (lo_we),
        .lo_i     (lo_i),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo; stimulus pushes expectations, a monitor
// compares them on the falling edge. Honours RF_BYPASS_EN like the design.
module tb_regfile_hilo;

    logic         clk;
    logic         rst;
    logic [103:0] wb_to_rf_bus;
    logic [4:0]   raddr1;
    logic [4:0]   raddr2;
    logic [31:0]  rdata1;
    logic [31:0]  rdata2;
    logic [31:0]  hi_rdata;
    logic [31:0]  lo_rdata;

    regfile_hilo dut (
        .clk          (clk),
        .rst          (rst),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    // Reference state
    logic [31:0] ref_gpr [32];
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Monitor: compare every pending expectation away from the active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            case (e.port)
                1:       got = rdata1;
                2:       got = rdata2;
                3:       got = hi_rdata;
                default: got = lo_rdata;
            endcase
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got %08h want %08h", e.name, got, e.exp);
            end
        end
    end

    function automatic logic [103:0] mk_bus(input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd, input logic hwe,
                                            input logic [31:0] hv, input logic lwe,
                                            input logic [31:0] lv);
        logic [103:0] b;
        b = '0;
        b[31:0]   = wd;
        b[36:32]  = wa;
        b[37]     = we;
        b[38]     = hwe;
        b[70:39]  = hv;
        b[71]     = lwe;
        b[103:72] = lv;
        return b;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [103:0] b);
        if (!rst || a == 5'd0) return 32'h0;
        if (BYPASS && b[37] && b[36:32] == a) return b[31:0];
        return ref_gpr[a];
    endfunction

    function automatic logic [31:0] exp_hi(input logic [103:0] b);
        if (!rst) return 32'h0;
        if (BYPASS && b[38]) return b[70:39];
        return ref_hi;
    endfunction

    function automatic logic [31:0] exp_lo(input logic [103:0] b);
        if (!rst) return 32'h0;
        if (BYPASS && b[71]) return b[103:72];
        return ref_lo;
    endfunction

    task automatic push(input string n, input int p, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.port = p;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        ref_hi = 32'h0;
        ref_lo = 32'h0;
    endtask

    task automatic push_all(input string tag, input logic [103:0] b,
                            input logic [4:0] a1, input logic [4:0] a2);
        push($sformatf("%s rdata1[%0d]", tag, a1), 1, exp_rd(a1, b));
        push($sformatf("%s rdata2[%0d]", tag, a2), 2, exp_rd(a2, b));
        push($sformatf("%s hi", tag), 3, exp_hi(b));
        push($sformatf("%s lo", tag), 4, exp_lo(b));
    endtask

    // One cycle: drive just after a rising edge, expect, then commit at the edge.
    task automatic cycle(input string tag, input logic [103:0] b,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_to_rf_bus = b;
        raddr1 = a1;
        raddr2 = a2;
        push_all(tag, b, a1, a2);
        @(posedge clk);
        if (rst) begin
            if (b[37] && b[36:32] != 5'd0) ref_gpr[b[36:32]] = b[31:0];
            if (b[38]) ref_hi = b[70:39];
            if (b[71]) ref_lo = b[103:72];
        end
        #1;
    endtask

    logic [103:0] idle;

    initial begin
        idle = '0;
        rst = 1'b0;
        wb_to_rf_bus = '0;
        raddr1 = '0;
        raddr2 = '0;
        clear_model();
        @(posedge clk);
        #1;

        // Reset held while a write to $5 is presented
        cycle("rst_hold", mk_bus(1, 5, 32'hDEADBEEF, 1, 32'h1111, 1, 32'h2222), 5, 5);
        cycle("rst_hold2", mk_bus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0), 5, 0);
        rst = 1'b1;
        cycle("rel_wr5", mk_bus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0), 5, 1);
        cycle("rd5", idle, 5, 5);

        // $0 stays zero
        cycle("wr0", mk_bus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0), 0, 0);
        cycle("rd0", idle, 0, 0);

        // Same-cycle write/read of $7
        cycle("wr7", mk_bus(1, 7, 32'h12345678, 0, 0, 0, 0), 5, 7);
        cycle("rd7", idle, 7, 7);

        // Simultaneous GPR/HI/LO write, then HI-only
        cycle("wr31hl", mk_bus(1, 31, 32'h1, 1, 32'hAAAA0000, 1, 32'h0000BBBB), 31, 0);
        cycle("rd31hl", idle, 31, 31);
        cycle("hi_only", mk_bus(0, 0, 0, 1, 32'h5A5A5A5A, 0, 32'hFFFFFFFF), 31, 7);
        cycle("after_hi", idle, 0, 31);

        // Fill all GPRs, then sweep both ports
        for (int a = 1; a < 32; a++)
            cycle("fill", mk_bus(1, 5'(a), 32'(a) * 32'h01010101, 0, 0, 0, 0), 5'(a), 5'(a - 1));
        for (int a = 0; a < 32; a++)
            cycle("sweep", idle, 5'(a), 5'((a * 7) % 32));

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [103:0] b;
            b = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = '0;
            cycle("rand", b, 5'($urandom_range(0, 31)), b[36:32]);
        end

        // Asynchronous reset mid-cycle with a write pending
        cycle("pre_rst", mk_bus(1, 9, 32'hCAFEF00D, 1, 32'h77, 1, 32'h88), 9, 3);
        wb_to_rf_bus = mk_bus(1, 5, 32'h0BADF00D, 1, 32'h99, 1, 32'h66);
        raddr1 = 5'd9;
        raddr2 = 5'd5;
        #2;
        rst = 1'b0;
        clear_model();
        push_all("async_rst", wb_to_rf_bus, raddr1, raddr2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("post_rst", idle, 9, 5);
        cycle("post_rst31", idle, 31, 1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
